// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// for addu, addiu, lw, sw and jal, trapping on anything else or on a stuck memory.
module mips_multicycle_ctrl #(
  parameter int STALL_LIMIT = 15,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic [3:0]  alu_ctrl,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        instr_done,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [3:0]  state_dbg
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WRITE = 4'd4;
  localparam logic [3:0] S_MEM_WB    = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_JUMP      = 4'd9;
  localparam logic [3:0] S_TRAP      = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       cause_q, cause_d;
  logic             rdst_r_q, rdst_r_d;
  logic             wait_st, stall_hit;
  logic [5:0]       opcode, funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  logic unused_ok;
  assign unused_ok = ^{instr[25:6], zero};

  assign wait_st   = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
  // The limit cycle is the STALL_LIMIT-th consecutive not-ready cycle; ready on it still wins.
  assign stall_hit = wait_st && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    trap_d   = trap_q;
    cause_d  = cause_q;
    rdst_r_d = rdst_r_q;
    cnt_d    = '0;
    if (wait_st && !mem_ready)
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW)               state_d = S_MEM_ADDR;
        else if (opcode == OP_ADDIU)                          state_d = S_EXEC_I;
        else if (opcode == OP_RTYPE && funct == FN_ADDU)      state_d = S_EXEC_R;
        else if (opcode == OP_JAL)                            state_d = S_JUMP;
        else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = 2'b01;
        end
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXEC_R: begin
        state_d  = S_ALU_WB;
        rdst_r_d = 1'b1;
      end
      S_EXEC_I: begin
        state_d  = S_ALU_WB;
        rdst_r_d = 1'b0;
      end
      S_MEM_WB, S_ALU_WB, S_JUMP: state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_FETCH;
    endcase
    if (stall_hit) begin
      state_d = S_TRAP;
      trap_d  = 1'b1;
      cause_d = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
      rdst_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      trap_q   <= trap_d;
      cause_q  <= cause_d;
      rdst_r_q <= rdst_r_d;
    end
  end

  // Outputs are forced low while reset is held so requests drop without waiting for an edge.
  always_comb begin
    alu_ctrl   = 4'b0000;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:    alu_src_b = 2'd2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_ctrl  = 4'b0001;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
          instr_done = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_ctrl  = 4'b0010;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = {1'b0, rdst_r_q};
          instr_done = 1'b1;
        end
        S_JUMP: begin
          alu_ctrl   = 4'b0011;
          alu_src_b  = 2'd3;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state_dbg  = reset ? S_FETCH : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Table-driven bench for mips_multicycle_ctrl: per-cycle expected output words are
// queued as each row is driven and compared on the following falling edge.
module tb_mips_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  alu_ctrl, state_dbg;
  logic        alu_src_a, i_or_d, mem_read, mem_write, ir_write, pc_write, reg_write;
  logic        instr_done, trap;
  logic [1:0]  alu_src_b, reg_dst, mem_to_reg, trap_cause;

  mips_multicycle_ctrl #(.STALL_LIMIT(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        rdy;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [24:0] obs;
  assign obs = {state_dbg, alu_ctrl, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                ir_write, pc_write, reg_write, reg_dst, mem_to_reg, instr_done, trap, trap_cause};

  function automatic logic [24:0] e(input logic [3:0] st, input logic [3:0] alu, input logic a,
      input logic [1:0] b, input logic iord, input logic mr, input logic mw, input logic irw,
      input logic pcw, input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
      input logic done, input logic tr, input logic [1:0] cause);
    return {st, alu, a, b, iord, mr, mw, irw, pcw, rw, rd, m2r, done, tr, cause};
  endfunction

  task automatic check(input string name, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add(input string n, input logic [31:0] i, input logic r,
                     input logic [24:0] x, input int reps = 1);
    for (int k = 0; k < reps; k++) begin
      vec_t v;
      v.name = $sformatf("%s[%0d]", n, k);
      v.instr = i; v.rdy = r; v.exp = x;
      vecs.push_back(v);
    end
  endtask

  // Each row: drive just after a rising edge, check on the falling edge.
  task automatic run_vecs();
    foreach (vecs[j]) begin
      vec_t c;
      instr     = vecs[j].instr;
      mem_ready = vecs[j].rdy;
      sb.push_back(vecs[j]);
      @(negedge clk);
      c = sb.pop_front();
      check(c.name, obs, c.exp);
      @(posedge clk);
      #1;
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("reset_outputs", obs, 25'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  localparam logic [31:0] ADDU   = 32'h00851021;
  localparam logic [31:0] ADD    = 32'h00851020;
  localparam logic [31:0] ADDIU  = 32'h24420005;
  localparam logic [31:0] LW     = 32'h8C820004;
  localparam logic [31:0] SW     = 32'hAC820008;
  localparam logic [31:0] JAL    = 32'h0C000010;
  localparam logic [31:0] ILLOP  = 32'hFC000000;

  logic [24:0] FET1, FET0, DEC, EXR, AWBR, EXI, AWBI, MA, MR0, MR1, MWB, MW0, MW1, JMP, TRP1, TRP2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            st    alu  a b iord mr mw irw pcw rw rd m2r dn tr cause
    FET1 = e(4'd0, 4'd0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    FET0 = e(4'd0, 4'd0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    DEC  = e(4'd1, 4'd0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MA   = e(4'd2, 4'd1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MR0  = e(4'd3, 4'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    MR1  = MR0;
    MW0  = e(4'd4, 4'd0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    MW1  = e(4'd4, 4'd0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    MWB  = e(4'd5, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
    EXR  = e(4'd6, 4'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    EXI  = e(4'd7, 4'd0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    AWBR = e(4'd8, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
    AWBI = e(4'd8, 4'd0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
    JMP  = e(4'd9, 4'd3, 0, 3, 0, 0, 0, 0, 1, 1, 2, 2, 1, 0, 0);
    TRP1 = e(4'd10, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01);
    TRP2 = e(4'd10, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10);

    do_reset();

    // addu: 0,1,6,8 then back to fetch
    add("addu_fetch", ADDU, 1, FET1);
    add("addu_dec",   ADDU, 1, DEC);
    add("addu_exec",  ADDU, 1, EXR);
    add("addu_wb",    ADDU, 1, AWBR);
    // lw with three wait cycles in MEM_READ: 8 cycles total
    add("lw_fetch",   LW, 1, FET1);
    add("lw_dec",     LW, 1, DEC);
    add("lw_addr",    LW, 1, MA);
    add("lw_wait",    LW, 0, MR0, 3);
    add("lw_read",    LW, 1, MR1);
    add("lw_wb",      LW, 0, MWB);
    // sw then jal back to back
    add("sw_fetch",   SW, 1, FET1);
    add("sw_dec",     SW, 1, DEC);
    add("sw_addr",    SW, 1, MA);
    add("sw_write",   SW, 1, MW1);
    add("jal_fetch",  JAL, 1, FET1);
    add("jal_dec",    JAL, 1, DEC);
    add("jal_jump",   JAL, 0, JMP);
    // addiu, then a fetch stalled 14 cycles with ready arriving on the 15th
    add("addiu_fetch", ADDIU, 1, FET1);
    add("addiu_dec",   ADDIU, 1, DEC);
    add("addiu_exec",  ADDIU, 1, EXI);
    add("addiu_wb",    ADDIU, 1, AWBI);
    add("stall14",     ILLOP, 0, FET0, 14);
    add("ready_at_limit", ILLOP, 1, FET1);
    add("illop_dec",   ILLOP, 1, DEC);
    add("illop_trap",  ILLOP, 1, TRP1, 10);
    add("illop_trap_nordy", ADDU, 0, TRP1, 10);
    run_vecs();

    // fetch never completes: bus error on the 15th not-ready cycle
    do_reset();
    add("stall15",    ADDU, 0, FET0, 15);
    add("bus_err",    ADDU, 1, TRP2, 3);
    run_vecs();

    // R-type with unsupported funct
    do_reset();
    add("add_fetch",  ADD, 1, FET1);
    add("add_dec",    ADD, 1, DEC);
    add("add_trap",   ADD, 1, TRP1, 2);
    run_vecs();

    // reset arriving while a store waits on memory
    do_reset();
    add("sw2_fetch",  SW, 1, FET1);
    add("sw2_dec",    SW, 1, DEC);
    add("sw2_addr",   SW, 1, MA);
    add("sw2_wait",   SW, 0, MW0, 2);
    run_vecs();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_mid_write", obs, 25'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    add("post_reset_fetch", ADDU, 1, FET1);
    add("post_reset_dec",   ADDU, 1, DEC);
    run_vecs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
